// File: rtl/cnt_pkg.sv
// Shared constants for the modulo up/down counter: direction encodings and a
// constant clog2 used to range-check the modulus at elaboration.
package cnt_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((64'(1) << bits) < 64'(value)) bits = bits + 1;
    return bits;
  endfunction

endpackage

// File: rtl/jk_ff_sr.sv
// Single JK flip-flop bit cell with synchronous active-high reset.
module jk_ff_sr (
  input  logic Clk,
  input  logic Rst,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Qc
);

  logic r_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_q <= 1'b0;
    end else begin
      case ({J, K})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign Q  = r_q;
  assign Qc = ~r_q;

endmodule

// File: rtl/syn_mod_updown_counter.sv
// Parametrised synchronous modulo up/down counter built from JK bit cells.
// Define CNT_SATURATE_EN to hold at the limits instead of wrapping.
module syn_mod_updown_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Up,
  output logic [WIDTH-1:0] Q,
  output logic             Tc
);

  import cnt_pkg::*;

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

  generate
    if (WIDTH < 1 || WIDTH > 16 || MOD < 2 || clog2(MOD) > WIDTH) begin : g_bad_param
      $error("syn_mod_updown_counter: illegal WIDTH/MOD combination");
    end
  endgenerate

  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_qc;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_load_ok;
  logic             w_tc;

  assign w_load_ok = (32'(D) < MOD);

  // Priority next-state: reset, then load (clamped), then count.
  always_comb begin
    w_nxt = Q;
    if (Rst) begin
      w_nxt = '0;
    end else if (Load) begin
      w_nxt = w_load_ok ? D : MAX_Q;
    end else if (En) begin
      if (Up == DIR_UP) begin
        if (Q == MAX_Q) begin
`ifdef CNT_SATURATE_EN
          w_nxt = MAX_Q;
`else
          w_nxt = '0;
`endif
        end else begin
          w_nxt = Q + WIDTH'(1);
        end
      end else begin
        if (Q == '0) begin
`ifdef CNT_SATURATE_EN
          w_nxt = '0;
`else
          w_nxt = MAX_Q;
`endif
        end else begin
          w_nxt = Q - WIDTH'(1);
        end
      end
    end
  end

  // Drive each JK cell so it lands on the requested next-state bit.
  assign w_j = w_nxt & w_qc;
  assign w_k = ~w_nxt & Q;

  generate
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      jk_ff_sr u_cell (
        .Q   (Q[i]),
        .Qc  (w_qc[i]),
        .J   (w_j[i]),
        .K   (w_k[i]),
        .Clk (Clk),
        .Rst (Rst)
      );
    end
  endgenerate

  assign w_tc = En & (((Up == DIR_UP) & (Q == MAX_Q)) | ((Up == DIR_DOWN) & (Q == '0)));
  assign Tc   = w_tc;

endmodule
